// File: rtl/dcache_assoc_if.sv
// CPU-side and memory-side bus bundles for the set-associative data cache.
// On the CPU bus the cache is the slave; on the memory bus it is the master.

interface dcache_assoc_cpu_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  cpu_req;
   logic                  cpu_we;
   logic                  cpu_byte;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [31:0]           cpu_wdata;
   logic [31:0]           cpu_rdata;
   logic                  cpu_ready;

   modport master (
      output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ready
   );
   modport slave (
      input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ready
   );
endinterface

interface dcache_assoc_mem_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  mem_ack;
   logic [31:0]           mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate, N-way set-associative data cache with one-word lines.
// Hits complete combinationally; misses run an optional victim write-back, a refill, then replay as a hit.

module dcache_assoc #(
   parameter int ADDR_WIDTH = 32,
   parameter int SETS       = 8,
   parameter int WAYS       = 2
) (
   input  logic                clk,
   input  logic                rst,
   dcache_assoc_cpu_if.slave   cpu,
   dcache_assoc_mem_if.master  mem,
   output logic [31:0]         hit_count,
   output logic [31:0]         miss_count
);

   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
   localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} cacheState_t;

   cacheState_t      state;
   logic [TAG_W-1:0] tagMem   [SETS][WAYS];
   logic [31:0]      dataMem  [SETS][WAYS];
   logic [WAY_W-1:0] ageBits  [SETS][WAYS];
   logic [WAYS-1:0]  validBits[SETS];
   logic [WAYS-1:0]  dirtyBits[SETS];

   logic [IDX_W-1:0] missIndex;
   logic [TAG_W-1:0] missTag;
   logic [WAY_W-1:0] victimWay;
   logic             fillPending;

   logic [IDX_W-1:0] cpuIndex;
   logic [TAG_W-1:0] cpuTag;
   logic [1:0]       cpuOffset;
   logic             hit;
   logic [WAY_W-1:0] hitWay;
   logic [31:0]      hitWord;
   logic [31:0]      mergedWord;
   logic [WAY_W-1:0] victimSel;
   logic [WAY_W-1:0] oldAge;
   logic             accessHit;

   assign cpuIndex  = cpu.cpu_addr[2 +: IDX_W];
   assign cpuTag    = cpu.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
   assign cpuOffset = cpu.cpu_addr[1:0];
   assign accessHit = (state == IDLE) && cpu.cpu_req && hit;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      logic foundInvalid;
      logic foundOldest;
      hit          = 1'b0;
      hitWay       = '0;
      victimSel    = '0;
      foundInvalid = 1'b0;
      foundOldest  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && validBits[cpuIndex][w] && (tagMem[cpuIndex][w] == cpuTag)) begin
            hit    = 1'b1;
            hitWay = WAY_W'(w);
         end
         if (!foundInvalid && !validBits[cpuIndex][w]) begin
            foundInvalid = 1'b1;
            victimSel    = WAY_W'(w);
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (!foundInvalid && !foundOldest && (ageBits[cpuIndex][w] == AGE_MAX)) begin
            foundOldest = 1'b1;
            victimSel   = WAY_W'(w);
         end
      end
      hitWord    = dataMem[cpuIndex][hitWay];
      mergedWord = hitWord;
      if (cpu.cpu_byte) mergedWord[{cpuOffset, 3'b000} +: 8] = cpu.cpu_wdata[7:0];
      else              mergedWord = cpu.cpu_wdata;
      // A freshly filled line replays as the oldest way, so every other way ages behind it.
      if (fillPending && (cpuIndex == missIndex) && (hitWay == victimWay)) oldAge = AGE_MAX;
      else                                                                  oldAge = ageBits[cpuIndex][hitWay];
   end

   always_comb begin
      cpu.cpu_ready = (state == IDLE) && (!cpu.cpu_req || hit);
      cpu.cpu_rdata = 32'd0;
      if (accessHit) begin
         if (cpu.cpu_byte) cpu.cpu_rdata = {24'd0, hitWord[{cpuOffset, 3'b000} +: 8]};
         else              cpu.cpu_rdata = hitWord;
      end
   end

   // NOTE: tag and data arrays are deliberately left out of reset; valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (accessHit && cpu.cpu_we) dataMem[cpuIndex][hitWay] <= mergedWord;
      if ((state == REFILL) && mem.mem_ack) begin
         dataMem[missIndex][victimWay] <= mem.mem_rdata;
         tagMem[missIndex][victimWay]  <= missTag;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all reads see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         hit_count     <= 32'd0;
         miss_count    <= 32'd0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= 32'd0;
         missIndex     <= '0;
         missTag       <= '0;
         victimWay     <= '0;
         fillPending   <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            validBits[s] <= '0;
            dirtyBits[s] <= '0;
            for (int w = 0; w < WAYS; w++) ageBits[s][w] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               fillPending <= 1'b0;
               if (cpu.cpu_req && hit) begin
                  if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                  for (int w = 0; w < WAYS; w++) begin
                     if (WAY_W'(w) == hitWay)              ageBits[cpuIndex][w] <= '0;
                     else if (ageBits[cpuIndex][w] < oldAge) ageBits[cpuIndex][w] <= ageBits[cpuIndex][w] + WAY_W'(1);
                  end
                  if (cpu.cpu_we) dirtyBits[cpuIndex][hitWay] <= 1'b1;
               end else if (cpu.cpu_req) begin
                  if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                  missIndex   <= cpuIndex;
                  missTag     <= cpuTag;
                  victimWay   <= victimSel;
                  mem.mem_req <= 1'b1;
                  if (validBits[cpuIndex][victimSel] && dirtyBits[cpuIndex][victimSel]) begin
                     state         <= WRITEBACK;
                     mem.mem_we    <= 1'b1;
                     mem.mem_addr  <= {tagMem[cpuIndex][victimSel], cpuIndex, 2'b00};
                     mem.mem_wdata <= dataMem[cpuIndex][victimSel];
                  end else begin
                     state        <= REFILL;
                     mem.mem_we   <= 1'b0;
                     mem.mem_addr <= {cpuTag, cpuIndex, 2'b00};
                  end
               end
            end
            WRITEBACK: begin
               if (mem.mem_ack) begin
                  dirtyBits[missIndex][victimWay] <= 1'b0;
                  state        <= REFILL;
                  mem.mem_we   <= 1'b0;
                  mem.mem_addr <= {missTag, missIndex, 2'b00};
               end
            end
            REFILL: begin
               if (mem.mem_ack) begin
                  validBits[missIndex][victimWay] <= 1'b1;
                  dirtyBits[missIndex][victimWay] <= 1'b0;
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
                  fillPending <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised write-back, write-allocate, N-way set-associative data cache that sits in the memory stage between the pipeline's Stage3/Stage4 registers and data memory. It is the successor to the single-way, always-write-through cache: a cache hit completes in the same cycle, while a miss stalls the pipeline through `cpu_ready`. On a miss the block runs a dirty-victim write-back and line refill over a req/ack memory handshake. Hit and miss counters are exposed for performance tests.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: byte address width.
- `SETS`, default 8: number of sets. Must be a power of 2, ≥2.
- `WAYS`, default 2: associativity. Must be a power of 2, from 1 to 8.

Line size is fixed at one 32-bit word.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  asynchronous, active-high reset.
- CPU side:
  - `cpu_req`  in  1  memory-stage access valid (load or store).
  - `cpu_we`  in  1  1 = store.
  - `cpu_byte`  in  1  1 = byte access, 0 = word access.
  - `cpu_addr`  in  ADDR_WIDTH  byte address.
  - `cpu_wdata`  in  32  store data (byte accesses use `[7:0]`).
  - `cpu_rdata`  out  32  load data; byte loads are zero-extended.
  - `cpu_ready`  out  1  access complete this cycle; pipeline stalls while this is low.
- Memory side:
  - `mem_req`  out  1  memory transaction valid.
  - `mem_we`  out  1  1 = write-back, 0 = refill read.
  - `mem_addr`  out  ADDR_WIDTH  word-aligned address (`[1:0]` = 0).
  - `mem_wdata`  out  32  victim data.
  - `mem_ack`  in  1  transaction done; `mem_rdata` is valid in the same cycle.
  - `mem_rdata`  in  32  refill data.
- Statistics:
  - `hit_count`  out  32  saturating count of hits.
  - `miss_count`  out  32  saturating count of misses.

## Operation

- Address split:
  - offset = `addr[1:0]`.
  - index = `addr[2 +: log2(SETS)]`.
  - tag = remaining upper bits.
  - With `SETS=1`-style degenerate widths disallowed, the tag is `ADDR_WIDTH-2-log2(SETS)` bits.
- Per-way state:
  - `valid` and `dirty` bits, plus a `log2(WAYS)`-bit age, all reset to 0.
  - Tag and data arrays are not reset.
- FSM states are IDLE, WRITEBACK and REFILL.
- IDLE, `cpu_req`=0: `cpu_ready`=1, no state change.
- IDLE, hit (valid and tag match in exactly one way):
  - `cpu_ready`=1 combinationally.
  - Load: `cpu_rdata` = word, or the byte selected by offset, zero-extended.
  - Store: on the clock edge, write the word or the byte lane selected by offset, and set dirty.
  - Hit way age becomes 0. Other ways with age < the old hit age increment (true LRU).
  - `hit_count` +1.
- IDLE, miss:
  - `cpu_ready`=0 and `miss_count` +1, counted once per miss, on the IDLE→miss edge only.
  - Victim = lowest-index invalid way; otherwise the way with age `WAYS-1`.
  - Victim index is latched.
  - Next state is WRITEBACK if the victim is valid and dirty, else REFILL.
- WRITEBACK:
  - `mem_req`=1, `mem_we`=1, `mem_addr` = {victim tag, index, 2'b00}, `mem_wdata` = victim data.
  - On `mem_ack`: clear victim dirty, go to REFILL.
- REFILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = {cpu tag, index, 2'b00}.
  - On `mem_ack`: write `mem_rdata` and tag into the victim, set valid, clear dirty, go to IDLE.
  - Age is not updated here; the access replays as a normal hit in IDLE, which updates LRU and, for a store, merges data and sets dirty.
- `cpu_ready`=0 in WRITEBACK and REFILL.
- The pipeline holds `cpu_*` stable while `cpu_ready`=0.
- If `cpu_req` drops mid-miss, the in-flight transaction still completes and the line is still installed.
- `WAYS=1`: age is width 0 and the victim is always way 0.
- Counters saturate at 0xFFFF_FFFF.

## Timing

- Reset, asynchronous, any state:
  - FSM → IDLE; all `valid`, `dirty` and age bits cleared.
  - Counters = 0; `mem_req`=0, `mem_we`=0.
  - `cpu_ready`=1 once `rst` deasserts; `cpu_rdata`=0 while no hit.
  - An in-flight memory transaction is abandoned; memory must tolerate a dropped request.
- Hit latency: 0 cycles (same-cycle `cpu_ready`).
- Clean miss, with memory ack after L cycles (ack in the L-th cycle of `mem_req`): the access completes in cycle L+1 after the miss cycle, which is the replayed hit.
- Dirty miss: 2 transactions, so the access completes in cycle L_wb+L_rf+1.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered, stable until the ack cycle, and fall in the cycle after ack. The exception is WRITEBACK→REFILL, where `mem_req` stays high and the address and `we` change.
- `mem_ack` while `mem_req`=0 is ignored.

## Test plan

- Reset then load `0x100`, SETS=8, WAYS=2, memory L=3, `mem[0x100]`=`0xDEADBEEF`:
  - `cpu_ready` is low for 4 cycles, then high with `cpu_rdata`=`0xDEADBEEF`.
  - `miss_count`=1, `hit_count`=1.
  - An immediate reload of `0x100` hits in 0 cycles.
- Byte store `0x103`←`0xAB` after the line holds `0xDEADBEEF`:
  - The next word load returns `0xABADBEEF`.
  - The next byte load of `0x101` returns `0x000000BE`.
  - The line is dirty and no memory write is issued.
- Fill both ways of index 0 (`0x000`, `0x020`) with stores, touch `0x000`, then load `0x040`:
  - Victim is the way holding `0x020`.
  - A WRITEBACK to `0x020` with the stored data precedes the REFILL of `0x040`.
  - `0x000` still hits afterward.
- Clean victim eviction: no WRITEBACK transaction is issued; the first `mem_req` cycle has `mem_we`=0.
- Assert `rst` during REFILL (cycle 2 of L=5):
  - `mem_req` falls immediately.
  - A subsequent load of the same address misses again.
  - Counters restart from 0.
- WAYS=1, SETS=4: alternating loads `0x00`/`0x10` miss every time, so `miss_count` equals the access count.
